toggle_decoder: RTL and testbench
=================================

TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port q  input  1  toggle-encoded line, the output of a T flip-flop; sampled only when sym_vld=1.
REQ-004 SHALL have port sym_vld  input  1  symbol strobe; one symbol per cycle when high.
REQ-005 SHALL have port t_out  output  1  recovered toggle bit, registered.
REQ-006 SHALL have port t_vld  output  1  one-cycle pulse qualifying t_out.
REQ-007 SHALL have port out_data  output  8  head word of the output FIFO.
REQ-008 SHALL have port out_vld  output  1  FIFO non-empty.
REQ-009 SHALL have port out_rdy  input  1  consumer accept; a pop occurs when out_vld=1 and out_rdy=1.
REQ-010 SHALL have port busy  output  1  high while the FSM is not in IDLE.
REQ-011 SHALL have port ovf  output  1  sticky overflow flag.
REQ-012 SHALL have port par_err  output  1  sticky parity-error flag.

Function
REQ-013 SHALL keep register prev (the last sampled q); on each sym_vld the recovered bit SHALL be q XOR prev, and prev SHALL be updated to q.
REQ-014 SHALL drive t_out and t_vld one cycle after the sym_vld sample (latency 1).
REQ-015 SHALL implement FSM states IDLE, DATA and PAR.
- IDLE -> DATA on a recovered bit of 1 (start bit).
- A recovered 0 in IDLE is ignored.
REQ-016 In DATA, the block SHALL shift 8 recovered bits LSB-first using a bit counter 0..7.
- The counter advances only on sym_vld.
- Idle cycles (sym_vld=0) SHALL NOT change state.
REQ-017 After the 8th data bit, the FSM SHALL go to PAR if the parity feature is compiled in, otherwise to IDLE with a push of the assembled word.
REQ-018 SHALL buffer words in a 2-entry FIFO.
- A pushed word becomes visible on out_data/out_vld the cycle after the final frame bit is sampled.
REQ-019 If a push occurs while the FIFO is full and no pop occurs in the same cycle, the word SHALL be dropped and ovf SHALL be set.
REQ-020 A simultaneous push and pop on a full FIFO SHALL accept the push, with no ovf.
REQ-021 A simultaneous push and pop on an empty FIFO is impossible (out_vld=0); the pushed word SHALL appear next cycle.
REQ-022 The FIFO read and write pointers SHALL wrap modulo 2.
- Occupancy SHALL be tracked 0..2, with no aliasing between full and empty.
REQ-023 out_data SHALL be held stable while out_vld=1 and out_rdy=0.
REQ-024 ovf and par_err SHALL remain set until clr.

Reset
REQ-025 clr=1 SHALL immediately force the following, independent of clk:
- prev=0, t_out=0, t_vld=0
- FSM=IDLE, bit counter=0, shift register=0
- FIFO empty, out_vld=0, out_data=0
- busy=0, ovf=0, par_err=0
REQ-026 clr asserted mid-frame SHALL discard the partial word.
- After release, decoding SHALL restart from IDLE with prev=0, matching the T flip-flop cleared state q=0.

Configuration
REQ-027 Macro TOGGLE_DECODER_PARITY_EN: when defined, each frame SHALL carry a 9th recovered bit in state PAR.
- The 8 data bits plus the parity bit SHALL have odd parity.
- A mismatch SHALL set par_err, and the word SHALL still be pushed.
- PAR -> IDLE.
REQ-028 Without TOGGLE_DECODER_PARITY_EN:
- The PAR state and parity logic SHALL be absent.
- The port par_err SHALL remain and be tied to 0.
- Frames SHALL be start bit plus 8 data bits.

Verification
REQ-029 Basic frame: clr pulse, then q=1,0,0,1,1,1,0,0,1 with sym_vld=1 each cycle and parity disabled -> out_data=0xA5, out_vld=1 one cycle after the last symbol; t_out sequence 1,1,0,1,0,0,1,0,1.
REQ-030 Backpressure: three back-to-back frames (0x01, 0x02, 0x03) with out_rdy=0 -> FIFO holds 0x01, 0x02; the third is dropped; ovf=1; out_data stays 0x01.
REQ-031 Simultaneous push/pop: FIFO full, out_rdy=1 in the cycle the third frame completes -> no ovf; pop order 0x01, 0x02, 0x03.
REQ-032 Reset mid-frame: assert clr after 4 data bits, release, then send 0x3C -> out_data=0x3C only; busy=0 during clr.
REQ-033 Gaps: the 0xA5 stream with sym_vld=0 inserted between every symbol -> identical result to REQ-029.
REQ-034 Parity (macro defined): frame 0xA5 (four ones) with parity bit t=0 -> par_err=1 and the word still pushed; with t=1 -> par_err=0.

Source files
------------

// File: rtl/toggle_decoder_if.sv
// Output word stream of toggle_decoder.
//   out_data : head word of the decoder's output FIFO
//   out_vld  : FIFO non-empty
//   out_rdy  : consumer accept
// Handshake: a word transfers on a rising clk edge where out_vld=1 and
// out_rdy=1. out_vld never depends on out_rdy, and out_data is held stable
// while out_vld=1 and out_rdy=0.
interface toggle_decoder_if;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;

  modport master (output out_data, output out_vld, input out_rdy);
  modport slave  (input out_data, input out_vld, output out_rdy);
endinterface

// File: rtl/toggle_decoder.sv
// toggle_decoder: recovers bits from a T-flip-flop encoded line (bit = q ^ previous q),
// frames them as start bit + 8 data bits LSB-first (+ odd parity bit when
// TOGGLE_DECODER_PARITY_EN is defined) and buffers words in a 2-entry FIFO.
// Ports:
//   clk       : clock, rising edge
//   clr       : asynchronous active-high reset
//   q         : encoded line, sampled when sym_vld=1
//   sym_vld   : symbol strobe
//   t_out     : recovered bit (registered), qualified by t_vld
//   t_vld     : one-cycle pulse, latency 1 from the sample
//   busy      : FSM not in IDLE
//   ovf       : sticky overflow (word dropped on full FIFO)
//   par_err   : sticky parity error (tied 0 without TOGGLE_DECODER_PARITY_EN)
//   dbg_state : current FSM state encoding
//   out_if    : output word stream (out_data / out_vld / out_rdy)
// Optional feature macro: TOGGLE_DECODER_PARITY_EN
module toggle_decoder (
  input  logic       clk,
  input  logic       clr,
  input  logic       q,
  input  logic       sym_vld,
  output logic       t_out,
  output logic       t_vld,
  output logic       busy,
  output logic       ovf,
  output logic       par_err,
  output logic [1:0] dbg_state,
  toggle_decoder_if.master out_if
);

`ifdef TOGGLE_DECODER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic        prev_q;
  logic        t_out_q, t_vld_q;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rec_bit;
  logic        push;
  logic [7:0]  push_data;
  logic        par_fail;

  logic [7:0]  mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  occ_q, occ_d;
  logic        pop, push_ok, drop;
  logic        ovf_q;

  assign rec_bit = q ^ prev_q;

  // Recovered-bit path and decoder state registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev_q  <= 1'b0;
      t_out_q <= 1'b0;
      t_vld_q <= 1'b0;
      state_q <= IDLE;
      bcnt_q  <= 3'd0;
      shreg_q <= 8'd0;
    end else begin
      t_vld_q <= sym_vld;
      if (sym_vld) begin
        prev_q  <= q;
        t_out_q <= rec_bit;
      end
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic; all transitions happen only on a symbol strobe
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    push_data = shreg_q;
    par_fail  = 1'b0;
    if (sym_vld) begin
      case (state_q)
        IDLE: begin
          if (rec_bit) begin
            state_d = DATA;
            bcnt_d  = 3'd0;
          end
        end
        DATA: begin
          shreg_d = {rec_bit, shreg_q[7:1]};  // LSB arrives first
          bcnt_d  = bcnt_q + 3'd1;            // wraps 7 -> 0 at end of data
          if (bcnt_q == 3'd7) begin
`ifdef TOGGLE_DECODER_PARITY_EN
            state_d = PAR;
`else
            state_d   = IDLE;
            push      = 1'b1;
            push_data = shreg_d;
`endif
          end
        end
`ifdef TOGGLE_DECODER_PARITY_EN
        PAR: begin
          state_d   = IDLE;
          push      = 1'b1;
          push_data = shreg_q;
          // odd parity: XOR over data plus parity bit must be 1
          par_fail  = ~(^{shreg_q, rec_bit});
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO control: a full FIFO still accepts a push when a pop frees the head
  assign pop     = (occ_q != 2'd0) && out_if.out_rdy;
  assign push_ok = push && ((occ_q != 2'd2) || pop);
  assign drop    = push && (occ_q == 2'd2) && !pop;

  always_comb begin
    occ_d = occ_q;
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_q[0] <= 8'd0;
      mem_q[1] <= 8'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

`ifdef TOGGLE_DECODER_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk or posedge clr) begin
    if (clr)           par_err_q <= 1'b0;
    else if (par_fail) par_err_q <= 1'b1;
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign out_if.out_data = mem_q[rd_ptr_q];
  assign out_if.out_vld  = (occ_q != 2'd0);
  assign t_out     = t_out_q;
  assign t_vld     = t_vld_q;
  assign busy      = (state_q != IDLE);
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_toggle_decoder.sv
module tb_toggle_decoder;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       q = 1'b0;
  logic       sym_vld = 1'b0;
  logic       t_out, t_vld, busy, ovf, par_err;
  logic [1:0] dbg_state;

  toggle_decoder_if out_if ();

  toggle_decoder dut (
    .clk       (clk),
    .clr       (clr),
    .q         (q),
    .sym_vld   (sym_vld),
    .t_out     (t_out),
    .t_vld     (t_vld),
    .busy      (busy),
    .ovf       (ovf),
    .par_err   (par_err),
    .dbg_state (dbg_state),
    .out_if    (out_if.slave)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];    // words expected to pop, in order
  logic [0:0] texp_q[$];   // recovered bits expected on t_out
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  // reference model: line level, frame assembly, FIFO occupancy, flags
  bit         q_line = 1'b0;
  bit         in_frame_m = 1'b0;
  int         nbits_m = 0;
  logic [7:0] word_m = 8'd0;
  int         occ_m = 0;
  bit         ovf_m = 1'b0;
  bit         par_err_m = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_note(input string name);
    chk_cnt++;
    $display("FAIL %s: unexpected DUT event at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!clr) begin
      if (t_vld) begin
        if (texp_q.size() == 0) fail_note("t_vld_extra");
        else check("t_out", {7'd0, t_out}, {7'd0, texp_q.pop_front()});
      end
      if (out_if.out_vld && out_if.out_rdy) begin
        if (exp_q.size() == 0) fail_note("pop_extra");
        else check("out_data_pop", out_if.out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic frame_model(input bit t, output bit push, output logic [7:0] w);
    push = 1'b0;
    w    = 8'd0;
    if (!in_frame_m) begin
      if (t) begin
        in_frame_m = 1'b1;
        nbits_m    = 0;
        word_m     = 8'd0;
      end
    end else if (nbits_m < 8) begin
      word_m[nbits_m] = t;
      nbits_m++;
`ifndef TOGGLE_DECODER_PARITY_EN
      if (nbits_m == 8) begin
        push = 1'b1;
        w = word_m;
        in_frame_m = 1'b0;
      end
`endif
    end else begin
      // parity bit: data ones plus parity must be odd
      if ((($countones(word_m) + int'(t)) % 2) == 0) par_err_m = 1'b1;
      push = 1'b1;
      w = word_m;
      in_frame_m = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: inputs applied just after a rising edge, the model
  // predicts the effect of the next rising edge.
  task automatic cycle(input bit vld, input bit t, input bit rdy);
    bit push, pop;
    logic [7:0] w;
    @(posedge clk);
    #1;
    if (vld) q_line ^= t;
    q = vld ? q_line : 1'($urandom_range(0, 1));
    sym_vld = vld;
    out_if.out_rdy = rdy;
    push = 1'b0;
    w = 8'd0;
    if (vld) begin
      texp_q.push_back(t);
      frame_model(t, push, w);
    end
    pop = (occ_m > 0) && rdy;
    if (push) begin
      if (occ_m < 2 || pop) begin
        exp_q.push_back(w);
        occ_m++;
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (pop) occ_m--;
  endtask

  // rdy_mode: 0/1 fixed, 2 random; last_rdy: -1 keep mode, else override final symbol
  // gap: 0 none, 1 one idle before each symbol, 2 random 0..2 idles
  task automatic send_frame(input logic [7:0] word, input int rdy_mode, input int last_rdy,
                            input int gap, input bit bad_par);
    bit bits[$];
    bit r;
    bits.push_back(1'b1);
    for (int i = 0; i < 8; i++) bits.push_back(word[i]);
`ifdef TOGGLE_DECODER_PARITY_EN
    bits.push_back((~(^word)) ^ bad_par);
`else
    if (bad_par) bits.push_back(1'b0);  // extra 0 is ignored in IDLE
`endif
    foreach (bits[i]) begin
      int n;
      n = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < n; k++)
        cycle(1'b0, 1'b0, (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode));
      r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
      if (i == bits.size() - 1 && last_rdy >= 0) r = 1'(last_rdy);
      cycle(1'b1, bits[i], r);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && occ_m > 0; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("drain_exp_empty", 8'(exp_q.size()), 8'd0);
    check("drain_out_vld", {7'd0, out_if.out_vld}, 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr = 1'b1;
    sym_vld = 1'b0;
    out_if.out_rdy = 1'b0;
    exp_q.delete();
    texp_q.delete();
    q_line = 1'b0;
    in_frame_m = 1'b0;
    nbits_m = 0;
    occ_m = 0;
    ovf_m = 1'b0;
    par_err_m = 1'b0;
    #2;
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_out_vld", {7'd0, out_if.out_vld}, 8'd0);
    check("rst_out_data", out_if.out_data, 8'd0);
    check("rst_ovf", {7'd0, ovf}, 8'd0);
    check("rst_par_err", {7'd0, par_err}, 8'd0);
    check("rst_t_vld", {7'd0, t_vld}, 8'd0);
    check("rst_t_out", {7'd0, t_out}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_held", {7'd0, busy}, 8'd0);
    clr = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ovf"}, {7'd0, ovf}, {7'd0, ovf_m});
    check({tag, "_par_err"}, {7'd0, par_err}, {7'd0, par_err_m});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    out_if.out_rdy = 1'b0;
    do_reset();

    // basic frame 0xA5, visible one cycle after last symbol
    send_frame(8'hA5, 0, -1, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("basic_out_vld", {7'd0, out_if.out_vld}, 8'd1);
    check("basic_out_data", out_if.out_data, 8'hA5);
    check("basic_busy", {7'd0, busy}, 8'd0);
    drain();

    // same stream with an idle cycle between every symbol
    do_reset();
    send_frame(8'hA5, 0, -1, 1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("gap_out_vld", {7'd0, out_if.out_vld}, 8'd1);
    check("gap_out_data", out_if.out_data, 8'hA5);
    drain();

    // backpressure: third word dropped, head holds 0x01
    do_reset();
    send_frame(8'h01, 0, -1, 0, 1'b0);
    send_frame(8'h02, 0, -1, 0, 1'b0);
    send_frame(8'h03, 0, -1, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ovf", {7'd0, ovf}, 8'd1);
    check("bp_head", out_if.out_data, 8'h01);
    check_flags("bp");
    drain();
    check("bp_ovf_sticky", {7'd0, ovf}, 8'd1);

    // simultaneous push/pop on full FIFO
    do_reset();
    send_frame(8'h01, 0, -1, 0, 1'b0);
    send_frame(8'h02, 0, -1, 0, 1'b0);
    send_frame(8'h03, 0, 1, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("sim_ovf", {7'd0, ovf}, 8'd0);
    check("sim_head", out_if.out_data, 8'h02);
    drain();

    // reset mid-frame: start + 4 data bits, then clean 0x3C
    do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    check("mid_busy_before_clr", {7'd0, busy}, 8'd1);
    do_reset();
    send_frame(8'h3C, 0, -1, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_out_data", out_if.out_data, 8'h3C);
    drain();

`ifdef TOGGLE_DECODER_PARITY_EN
    do_reset();
    send_frame(8'hA5, 0, -1, 0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("par_bad_err", {7'd0, par_err}, 8'd1);
    check("par_bad_word", out_if.out_data, 8'hA5);
    drain();
    do_reset();
    send_frame(8'hA5, 0, -1, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("par_ok_err", {7'd0, par_err}, 8'd0);
    check("par_ok_word", out_if.out_data, 8'hA5);
    drain();
`endif

    // randomized frames, gaps, backpressure and occasional parity faults
    do_reset();
    for (int f = 0; f < 40; f++) begin
      send_frame(8'($urandom_range(0, 255)), 2, -1, 2, ($urandom_range(0, 7) == 0));
      if ((f % 10) == 9) begin
        @(negedge clk);
        check_flags("rand");
      end
    end
    drain();
    check_flags("rand_end");
    check("rand_texp_empty", 8'(texp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
